vid_stream_gen: RTL and testbench

// - AXI4-Stream video transmitter: walks a TC x TR raster, emits IC x IR active pixels per frame with

---
 rtl/vid_stream_gen.sv | 197 +++++++++++++++++++
 tb/tb_vid_stream_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : vid_stream_gen
// Description : AXI4-Stream video raster generator with test patterns.
//               Optional frame/stall counters enabled by VGEN_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_stream_gen #(
   parameter int DW     = 8,
   parameter int IC     = 48,
   parameter int IR     = 32,
   parameter int TC     = 64,
   parameter int TR     = 40,
   parameter int ICW    = 11,
   parameter int IRW    = 11,
   parameter int REG_DW = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_DW-1:0]   reg_cfg,
   input  logic                m_pix_tready,
   output logic [DW-1:0]       m_pix_tdata,
   output logic                m_pix_tvalid,
   output logic [3:0]          m_pix_tuser,
   output logic                m_pix_tlast,
   output logic [REG_DW-1:0]   reg_sta,
   output logic [2*REG_DW-1:0] reg_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2,
      S_VBLANK = 2'd3
   } state_t;

   localparam logic [ICW-1:0] c_ic_last = ICW'(IC - 1);
   localparam logic [ICW-1:0] c_tc_last = ICW'(TC - 1);
   localparam logic [IRW-1:0] c_ir_last = IRW'(IR - 1);
   localparam logic [IRW-1:0] c_tr_last = IRW'(TR - 1);

   generate
      if (TC <= IC) begin : g_bad_tc
         $error("vid_stream_gen: TC must be greater than IC");
      end
      if (TR <= IR) begin : g_bad_tr
         $error("vid_stream_gen: TR must be greater than IR");
      end
   endgenerate

   state_t          r_state, w_nstate;
   logic [ICW-1:0]  r_x, w_nx;
   logic [IRW-1:0]  r_y, w_ny;
   logic [1:0]      r_pat, w_npat;
   logic [DW-1:0]   r_const, w_nconst;
   logic            w_frame_done;
   logic            w_fire;
   logic            w_stalled;

   logic            r_tvalid, w_nvalid;
   logic [DW-1:0]   r_tdata, w_ndata;
   logic [3:0]      r_tuser, w_nuser;

   assign w_fire    = r_tvalid & m_pix_tready;
   assign w_stalled = r_tvalid & ~m_pix_tready;

   // Next raster position / state
   always_comb begin
      w_nstate     = r_state;
      w_nx         = r_x;
      w_ny         = r_y;
      w_npat       = r_pat;
      w_nconst     = r_const;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (reg_cfg[0]) begin
               w_nstate = S_ACTIVE;
               w_nx     = '0;
               w_ny     = '0;
               w_npat   = reg_cfg[2:1];
               w_nconst = reg_cfg[8 +: DW];
            end
         end
         S_ACTIVE: begin
            if (w_fire) begin
               w_nx = r_x + 1'b1;
               if (r_x == c_ic_last) w_nstate = S_HBLANK;
            end
         end
         S_HBLANK: begin
            if (r_x == c_tc_last) begin
               w_nx     = '0;
               w_ny     = r_y + 1'b1;
               w_nstate = (r_y == c_ir_last) ? S_VBLANK : S_ACTIVE;
            end else begin
               w_nx = r_x + 1'b1;
            end
         end
         S_VBLANK: begin
            if (r_x == c_tc_last) begin
               w_nx = '0;
               if (r_y == c_tr_last) begin
                  w_ny         = '0;
                  w_frame_done = 1'b1;
                  if (reg_cfg[0]) begin
                     w_nstate = S_ACTIVE;
                     w_npat   = reg_cfg[2:1];
                     w_nconst = reg_cfg[8 +: DW];
                  end else begin
                     w_nstate = S_IDLE;
                  end
               end else begin
                  w_ny = r_y + 1'b1;
               end
            end else begin
               w_nx = r_x + 1'b1;
            end
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next position so they come straight from flops
   always_comb begin
      w_nvalid = (w_nstate == S_ACTIVE);
      w_ndata  = '0;
      w_nuser  = '0;
      if (w_nvalid) begin
         w_nuser[1] = (w_nx == '0);
         w_nuser[0] = (w_nx == c_ic_last);
         w_nuser[3] = (w_nx == '0) && (w_ny == '0);
         w_nuser[2] = (w_nx == c_ic_last) && (w_ny == c_ir_last);
         case (w_npat)
            2'd0:    w_ndata = DW'(w_nx);
            2'd1:    w_ndata = DW'(w_ny);
            2'd2:    w_ndata = {DW{w_nx[3] ^ w_ny[3]}};
            default: w_ndata = w_nconst;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_pat    <= '0;
         r_const  <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tuser  <= '0;
      end else begin
         r_state  <= w_nstate;
         r_x      <= w_nx;
         r_y      <= w_ny;
         r_pat    <= w_npat;
         r_const  <= w_nconst;
         r_tvalid <= w_nvalid;
         r_tdata  <= w_ndata;
         r_tuser  <= w_nuser;
      end
   end

   assign m_pix_tvalid = r_tvalid;
   assign m_pix_tdata  = r_tdata;
   assign m_pix_tuser  = r_tuser;
   assign m_pix_tlast  = r_tuser[0];

   assign reg_sta = {{(REG_DW-4){1'b0}}, w_stalled, r_state, (r_state != S_IDLE)};

`ifdef VGEN_STATUS_EN
   logic [REG_DW-1:0] r_frame_cnt;
   logic [REG_DW-1:0] r_stall_cnt;
   logic              w_unused;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
         if (w_stalled)    r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign reg_cnt  = {r_stall_cnt, r_frame_cnt};
   assign w_unused = ^reg_cfg;
`else
   logic w_unused;

   assign reg_cnt  = '0;
   assign w_unused = ^{reg_cfg, w_frame_done};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vid_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_stream_gen
// Description : Self-checking bench for vid_stream_gen against a raster model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_stream_gen;

   localparam int DW        = 8;
   localparam int IC        = 48;
   localparam int IR        = 32;
   localparam int TC        = 64;
   localparam int TR        = 40;
   localparam int REG_DW    = 32;
   localparam int FRAME_CYC = TC * TR;
   localparam int FRAME_PIX = IC * IR;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [REG_DW-1:0]   reg_cfg = '0;
   logic                m_pix_tready = 1'b0;
   logic [DW-1:0]       m_pix_tdata;
   logic                m_pix_tvalid;
   logic [3:0]          m_pix_tuser;
   logic                m_pix_tlast;
   logic [REG_DW-1:0]   reg_sta;
   logic [2*REG_DW-1:0] reg_cnt;

   int tests  = 0;
   int errors = 0;

   vid_stream_gen #(
      .DW(DW), .IC(IC), .IR(IR), .TC(TC), .TR(TR),
      .ICW(11), .IRW(11), .REG_DW(REG_DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .reg_cfg      (reg_cfg),
      .m_pix_tready (m_pix_tready),
      .m_pix_tdata  (m_pix_tdata),
      .m_pix_tvalid (m_pix_tvalid),
      .m_pix_tuser  (m_pix_tuser),
      .m_pix_tlast  (m_pix_tlast),
      .reg_sta      (reg_sta),
      .reg_cnt      (reg_cnt)
   );

   always #5 clk = ~clk;

   // Reference pixel value for a raster position
   function automatic logic [DW-1:0] f_data(input int x, input int y, input int pat, input int cval);
      case (pat)
         0:       return DW'(x);
         1:       return DW'(y);
         2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? {DW{1'b1}} : {DW{1'b0}};
         default: return DW'(cval);
      endcase
   endfunction

   function automatic logic [3:0] f_user(input int x, input int y);
      return {(x == 0 && y == 0), (x == IC-1 && y == IR-1), (x == 0), (x == IC-1)};
   endfunction

   task automatic do_reset(input logic [REG_DW-1:0] cfg);
      rst = 1'b1;
      reg_cfg = cfg;
      m_pix_tready = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive tready for the coming edge and report whether a beat transfers
   task automatic cycle(input bit rdy, output bit fire);
      @(negedge clk);
      m_pix_tready = rdy;
      #1;
      fire = m_pix_tvalid && rdy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      reg_cfg = 1;
      m_pix_tready = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      tests++; if (m_pix_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_pix_tvalid); end
      tests++; if (m_pix_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 00", m_pix_tdata); end
      tests++; if (m_pix_tuser !== 4'b0) begin errors++; $display("FAIL reset_tuser got %b want 0000", m_pix_tuser); end
      tests++; if (m_pix_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_pix_tlast); end
      tests++; if (reg_sta !== '0) begin errors++; $display("FAIL reset_sta got %h want 0", reg_sta); end
      tests++; if (reg_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", reg_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_raster();
      int ex = 0, ey = 0, beats = 0, sofs = 0, sof_cyc = 0;
      bit fire;
      do_reset(1);
      for (int cyc = 0; cyc < 3*FRAME_CYC && sofs < 2; cyc++) begin
         cycle(1'b1, fire);
         if (!fire) continue;
         if (m_pix_tuser[3]) begin
            sofs++;
            if (sofs == 1) sof_cyc = cyc;
            else begin
               tests++; if (cyc - sof_cyc != FRAME_CYC) begin errors++; $display("FAIL raster_sof_period got %0d want %0d", cyc - sof_cyc, FRAME_CYC); end
               tests++; if (beats != FRAME_PIX) begin errors++; $display("FAIL raster_beats got %0d want %0d", beats, FRAME_PIX); end
            end
         end
         if (sofs != 1) continue;
         if (beats == 0) begin
            tests++; if ({m_pix_tdata, m_pix_tuser, m_pix_tlast} !== {8'h00, 4'b1010, 1'b0}) begin
               errors++; $display("FAIL raster_first got %h/%b/%b want 00/1010/0", m_pix_tdata, m_pix_tuser, m_pix_tlast); end
         end
         if (ex == 47 && ey == 0) begin
            tests++; if ({m_pix_tdata, m_pix_tuser, m_pix_tlast} !== {8'h2F, 4'b0001, 1'b1}) begin
               errors++; $display("FAIL raster_eol0 got %h/%b/%b want 2f/0001/1", m_pix_tdata, m_pix_tuser, m_pix_tlast); end
         end
         if (ex == IC-1 && ey == IR-1) begin
            tests++; if (m_pix_tuser !== 4'b0101) begin errors++; $display("FAIL raster_last got %b want 0101", m_pix_tuser); end
         end
         tests++; if ({m_pix_tdata, m_pix_tuser, m_pix_tlast} !== {f_data(ex, ey, 0, 0), f_user(ex, ey), (ex == IC-1)}) begin
            errors++; $display("FAIL raster_beat(%0d,%0d) got %h/%b want %h/%b", ex, ey, m_pix_tdata, m_pix_tuser, f_data(ex, ey, 0, 0), f_user(ex, ey)); end
         beats++;
         ex++; if (ex == IC) begin ex = 0; ey++; end
      end
      tests++; if (sofs < 2) begin errors++; $display("FAIL raster_timeout got %0d sof want 2", sofs); end
   endtask

   task automatic test_backpressure();
      int ex = 0, ey = 0, beats = 0, stalls = 0;
      bit fire, rdy, prev_stall = 0;
      logic [DW-1:0] pd = '0;
      logic [3:0] pu = '0;
      logic pl = 1'b0;
      do_reset(1);
      for (int cyc = 0; cyc < 4*FRAME_CYC && beats < FRAME_PIX; cyc++) begin
         rdy = ($urandom_range(0, 1) == 1);
         cycle(rdy, fire);
         if (prev_stall) begin
            tests++; if ({m_pix_tvalid, m_pix_tdata, m_pix_tuser, m_pix_tlast} !== {1'b1, pd, pu, pl}) begin
               errors++; $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", m_pix_tvalid, m_pix_tdata, m_pix_tuser, pd, pu); end
         end
         prev_stall = m_pix_tvalid && !rdy;
         pd = m_pix_tdata; pu = m_pix_tuser; pl = m_pix_tlast;
         if (prev_stall) begin
            stalls++;
            tests++; if (reg_sta[3] !== 1'b1) begin errors++; $display("FAIL stall_flag got %b want 1", reg_sta[3]); end
         end
         if (fire) begin
            tests++; if ({m_pix_tdata, m_pix_tuser, m_pix_tlast} !== {f_data(ex, ey, 0, 0), f_user(ex, ey), (ex == IC-1)}) begin
               errors++; $display("FAIL bp_beat(%0d,%0d) got %h/%b want %h/%b", ex, ey, m_pix_tdata, m_pix_tuser, f_data(ex, ey, 0, 0), f_user(ex, ey)); end
            beats++;
            ex++; if (ex == IC) begin ex = 0; ey++; end
         end
      end
      tests++; if (beats != FRAME_PIX) begin errors++; $display("FAIL bp_beats got %0d want %0d", beats, FRAME_PIX); end
      repeat (4) cycle(1'b1, fire);
`ifdef VGEN_STATUS_EN
      tests++; if (reg_cnt[2*REG_DW-1:REG_DW] !== REG_DW'(stalls)) begin
         errors++; $display("FAIL bp_stall_cnt got %0d want %0d", reg_cnt[2*REG_DW-1:REG_DW], stalls); end
`else
      tests++; if (reg_cnt !== '0) begin errors++; $display("FAIL bp_cnt_absent got %h want 0", reg_cnt); end
`endif
   endtask

   task automatic test_disable();
      int ex = 0, ey = 0, after = 0, extra_valid = 0;
      bit fire, dropped = 0, done = 0;
      do_reset(1);
      for (int cyc = 0; cyc < 3*FRAME_CYC && !done; cyc++) begin
         cycle(($urandom_range(0, 3) != 0), fire);
         if (m_pix_tvalid && ex == 0 && ey == 10 && !dropped) begin
            reg_cfg = 0;
            dropped = 1;
         end
         if (fire) begin
            tests++; if ({m_pix_tdata, m_pix_tuser} !== {f_data(ex, ey, 0, 0), f_user(ex, ey)}) begin
               errors++; $display("FAIL dis_beat(%0d,%0d) got %h/%b want %h/%b", ex, ey, m_pix_tdata, m_pix_tuser, f_data(ex, ey, 0, 0), f_user(ex, ey)); end
            if (dropped) after++;
            if (ex == IC-1 && ey == IR-1) done = 1;
            ex++; if (ex == IC) begin ex = 0; ey++; end
         end
      end
      tests++; if (after != (IR-10)*IC) begin errors++; $display("FAIL dis_remaining got %0d want %0d", after, (IR-10)*IC); end
      for (int cyc = 0; cyc < FRAME_CYC + 100; cyc++) begin
         cycle(1'b1, fire);
         if (m_pix_tvalid) extra_valid++;
      end
      tests++; if (extra_valid != 0) begin errors++; $display("FAIL dis_idle_valid got %0d want 0", extra_valid); end
      tests++; if (reg_sta[2:0] !== 3'b000) begin errors++; $display("FAIL dis_sta got %b want 000", reg_sta[2:0]); end
   endtask

   task automatic test_reset_midframe();
      int ex = 0, ey = 0;
      bit fire, hit = 0, got = 0;
      do_reset(1);
      for (int cyc = 0; cyc < 2*FRAME_CYC && !hit; cyc++) begin
         cycle(1'b1, fire);
         if (m_pix_tvalid && ex == 20 && ey == 3) begin
            rst = 1'b1;
            hit = 1;
         end else if (fire) begin
            ex++; if (ex == IC) begin ex = 0; ey++; end
         end
      end
      tests++; if (!hit) begin errors++; $display("FAIL rstmid_reach got 0 want 1"); end
      cycle(1'b1, fire);
      tests++; if (m_pix_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m_pix_tvalid); end
      tests++; if (reg_sta !== '0) begin errors++; $display("FAIL rstmid_sta got %h want 0", reg_sta); end
      tests++; if ({m_pix_tdata, m_pix_tuser} !== '0) begin errors++; $display("FAIL rstmid_out got %h/%b want 0", m_pix_tdata, m_pix_tuser); end
      repeat (9) cycle(1'b1, fire);
      rst = 1'b0;
      for (int cyc = 0; cyc < 20 && !got; cyc++) begin
         cycle(1'b1, fire);
         if (m_pix_tvalid) got = 1;
      end
      tests++; if ({got, m_pix_tuser, m_pix_tdata} !== {1'b1, 4'b1010, 8'h00}) begin
         errors++; $display("FAIL rstmid_restart got %b/%b/%h want 1/1010/00", got, m_pix_tuser, m_pix_tdata); end
   endtask

   task automatic test_pattern();
      int ex = 0, ey = 0, frame = 0, pat = 2, cval = 0;
      bit fire, switched = 0;
      logic [DW-1:0] exp;
      do_reset(5);
      for (int cyc = 0; cyc < 3*FRAME_CYC && frame < 2; cyc++) begin
         cycle(($urandom_range(0, 7) != 0), fire);
         if (m_pix_tvalid && frame == 0 && ex == 0 && ey == 16 && !switched) begin
            reg_cfg = 32'h0000_5A07;
            switched = 1;
         end
         if (!fire) continue;
         exp = f_data(ex, ey, pat, cval);
         if (frame == 0 && ((ex == 0 && ey == 0) || (ex == 8 && ey == 8))) begin
            tests++; if (m_pix_tdata !== 8'h00) begin errors++; $display("FAIL pat2_zero(%0d,%0d) got %h want 00", ex, ey, m_pix_tdata); end
         end
         if (frame == 0 && ex == 8 && ey == 0) begin
            tests++; if (m_pix_tdata !== 8'hFF) begin errors++; $display("FAIL pat2_ones got %h want ff", m_pix_tdata); end
         end
         tests++; if ({m_pix_tdata, m_pix_tuser} !== {exp, f_user(ex, ey)}) begin
            errors++; $display("FAIL pat_beat f%0d(%0d,%0d) got %h/%b want %h/%b", frame, ex, ey, m_pix_tdata, m_pix_tuser, exp, f_user(ex, ey)); end
         ex++;
         if (ex == IC) begin ex = 0; ey++; end
         if (ey == IR) begin ey = 0; frame++; pat = 3; cval = 'h5A; end
      end
      tests++; if (frame != 2) begin errors++; $display("FAIL pat_frames got %0d want 2", frame); end
   endtask

   task automatic test_frame_count();
      int sofs = 0;
      bit fire;
      do_reset(1);
      for (int cyc = 0; cyc < 3*FRAME_CYC + 100 && sofs < 3; cyc++) begin
         cycle(1'b1, fire);
         if (fire && m_pix_tuser[3]) sofs++;
      end
      tests++; if (sofs != 3) begin errors++; $display("FAIL fc_sofs got %0d want 3", sofs); end
      tests++; if (reg_sta[0] !== 1'b1) begin errors++; $display("FAIL fc_busy got %b want 1", reg_sta[0]); end
`ifdef VGEN_STATUS_EN
      tests++; if (reg_cnt[REG_DW-1:0] !== 32'd2) begin errors++; $display("FAIL fc_frames got %0d want 2", reg_cnt[REG_DW-1:0]); end
      tests++; if (reg_cnt[2*REG_DW-1:REG_DW] !== 32'd0) begin errors++; $display("FAIL fc_stalls got %0d want 0", reg_cnt[2*REG_DW-1:REG_DW]); end
`else
      tests++; if (reg_cnt !== '0) begin errors++; $display("FAIL fc_cnt_absent got %h want 0", reg_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_raster();
      test_backpressure();
      test_disable();
      test_reset_midframe();
      test_pattern();
      test_frame_count();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
`default_nettype wire
